// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction-fetch front end placed directly ahead of the IF/ID
//             register. It owns the fetch PC and issues word reads to a
//             registered instruction memory with 1-cycle latency. Returned
//             words are buffered with their PCs in a small prefetch queue, and
//             one instruction per cycle is presented downstream. A redirect
//             flushes every buffered and in-flight fetch.
//  Ports    : clock, reset        - clock (rising edge), sync active-high reset
//             redirect/redirectPc - taken control transfer and its target
//             stall               - IF/ID not accepting, hold the head entry
//             imemReq/imemAddr    - instruction memory read request/address
//             imemData            - read data, valid the cycle after imemReq
//             validOut/instOut/pcOut/pcAdd4Out - head entry toward IF/ID
//             bubbleCnt/redirectCnt - perf counters (FETCH_PERF_EN only)
//  Options  : `define FETCH_PERF_EN adds saturating bubble/redirect counters.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  input  logic        stall,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemData,
  output logic        validOut,
  output logic [31:0] instOut,
  output logic [31:0] pcOut,
  output logic [31:0] pcAdd4Out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] bubbleCnt,
  output logic [31:0] redirectCnt
`endif
);

  localparam int          PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CNT_W  = PTR_W + 1;
  localparam int          OCC_W  = CNT_W + 1;
  localparam logic [OCC_W-1:0] OCC_DEPTH = OCC_W'(DEPTH);
  localparam logic [31:0] NOP    = 32'h0000_0013;

  // Queue storage (data path only, no reset needed)
  logic [31:0] pcMem_q   [DEPTH];
  logic [31:0] instMem_q [DEPTH];

  // Control state
  logic [31:0]      fetchPc_q, fetchPc_d;
  logic [31:0]      reqPc_q, reqPc_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic             headValid;
  logic             deq;
  logic             enq;
  logic             issue;
  logic [OCC_W-1:0] occAfterDeq;

  assign headValid = (count_q != '0);

  // A redirect hides the wrong-path head in the same cycle so IF/ID never
  // consumes it; reset hides whatever state existed before the reset edge.
  assign validOut = headValid && !redirect && !reset;
  assign deq      = validOut && !stall;

  // A response is written into the queue unless a flush is happening now.
  assign enq = inflight_q && !redirect;

  // Occupancy counts queued entries plus the outstanding read, minus the
  // entry leaving this cycle. Crediting the dequeue keeps the stream
  // gap-free at DEPTH=2; when stalled it reduces to count + inflight, so
  // a returning response always has a free slot.
  assign occAfterDeq = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(deq);
  assign issue       = !reset && !redirect && (occAfterDeq < OCC_DEPTH);

  assign imemReq  = issue;
  assign imemAddr = reset ? RESET_PC : fetchPc_q;

  assign instOut   = validOut ? instMem_q[head_q] : NOP;
  assign pcOut     = validOut ? pcMem_q[head_q] : 32'h0;
  assign pcAdd4Out = validOut ? (pcMem_q[head_q] + 32'd4) : 32'h0;

  always_comb begin
    fetchPc_d  = fetchPc_q;
    reqPc_d    = reqPc_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (redirect) begin
      // Flush: drop queue and any in-flight read, refetch from the target.
      fetchPc_d  = redirectPc & ~32'd3;
      inflight_d = 1'b0;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        reqPc_d   = fetchPc_q;
        fetchPc_d = fetchPc_q + 32'd4;
      end
      if (enq) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (deq) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetchPc_q  <= RESET_PC;
      reqPc_q    <= 32'h0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetchPc_q  <= fetchPc_d;
      reqPc_q    <= reqPc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && enq) begin
      pcMem_q[tail_q]   <= reqPc_q;
      instMem_q[tail_q] <= imemData;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] bubbleCnt_q;
  logic [31:0] redirectCnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      bubbleCnt_q   <= 32'h0;
      redirectCnt_q <= 32'h0;
    end else begin
      if (!validOut && !stall && (bubbleCnt_q != 32'hFFFF_FFFF)) begin
        bubbleCnt_q <= bubbleCnt_q + 32'd1;
      end
      if (redirect && (redirectCnt_q != 32'hFFFF_FFFF)) begin
        redirectCnt_q <= redirectCnt_q + 32'd1;
      end
    end
  end

  assign bubbleCnt   = bubbleCnt_q;
  assign redirectCnt = redirectCnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Directed self-checking bench for fetch_queue. Memory word at
//             byte address A holds A>>2, so each head instruction must equal
//             its PC shifted right by two.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = 32'h0;
  logic        stall = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemData = 32'h0;
  logic        validOut;
  logic [31:0] instOut;
  logic [31:0] pcOut;
  logic [31:0] pcAdd4Out;
`ifdef FETCH_PERF_EN
  logic [31:0] bubbleCnt;
  logic [31:0] redirectCnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int bub_exp = 0;
  int redir_exp = 0;

  fetch_queue #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .stall      (stall),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemData   (imemData),
    .validOut   (validOut),
    .instOut    (instOut),
    .pcOut      (pcOut),
    .pcAdd4Out  (pcAdd4Out)
`ifdef FETCH_PERF_EN
    ,
    .bubbleCnt   (bubbleCnt),
    .redirectCnt (redirectCnt)
`endif
  );

  always #5 clock = ~clock;

  // Registered instruction memory: word[i] = i; poison when not requested.
  always @(posedge clock) begin
    if (imemReq) imemData <= {2'b00, imemAddr[31:2]};
    else         imemData <= 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then check the outputs.
  task automatic step(input string tag, input logic rs, input logic rd,
                      input logic [31:0] rp, input logic st,
                      input logic ev, input logic [31:0] epc,
                      input logic ereq, input logic [31:0] eaddr);
    @(negedge clock);
    reset = rs; redirect = rd; redirectPc = rp; stall = st;
    #1;
    check({tag, ".valid"}, {31'b0, validOut}, {31'b0, ev});
    if (ev) begin
      check({tag, ".pc"},   pcOut,     epc);
      check({tag, ".inst"}, instOut,   {2'b00, epc[31:2]});
      check({tag, ".pc4"},  pcAdd4Out, epc + 32'd4);
    end else begin
      check({tag, ".inst"}, instOut,   NOP);
      check({tag, ".pc"},   pcOut,     32'h0);
      check({tag, ".pc4"},  pcAdd4Out, 32'h0);
    end
    check({tag, ".req"}, {31'b0, imemReq}, {31'b0, ereq});
    if (ereq) check({tag, ".addr"}, imemAddr, eaddr);
    if (!ev && !st && !rs) bub_exp++;
    if (rd && !rs) redir_exp++;
  endtask

  initial begin
    // Power-on reset
    step("rst0", 1, 0, 0, 0, 0, 0, 0, 0);
    check("rst0.addr", imemAddr, 32'h0);
    step("rst1", 1, 0, 0, 0, 0, 0, 0, 0);
    check("rst1.addr", imemAddr, 32'h0);

    // Start-up latency and gap-free stream
    step("c0", 0, 0, 0, 0, 0, 0, 1, 32'h0);
    step("c1", 0, 0, 0, 0, 0, 0, 1, 32'h4);
    for (int k = 2; k < 4; k++)
      step("run", 0, 0, 0, 0, 1, 32'(4 * (k - 2)), 1, 32'(4 * k));

    // Stall 10 cycles with head at PC 8; issue stops once full
    for (int k = 0; k < 10; k++)
      step("stall", 0, 0, 0, 1, 1, 32'h8, 0, 0);
    step("rel0", 0, 0, 0, 0, 1, 32'h8,  1, 32'h10);
    step("rel1", 0, 0, 0, 0, 1, 32'hC,  1, 32'h14);
    step("rel2", 0, 0, 0, 0, 1, 32'h10, 1, 32'h18);

    // Redirect to unaligned target; stale responses must never appear
    step("rdN",  0, 1, 32'h103, 0, 0, 0, 0, 0);
    step("rdN1", 0, 0, 0, 0, 0, 0, 1, 32'h100);
    step("rdN2", 0, 0, 0, 0, 0, 0, 1, 32'h104);
    step("rdN3", 0, 0, 0, 0, 1, 32'h100, 1, 32'h108);
    step("rdN4", 0, 0, 0, 0, 1, 32'h104, 1, 32'h10C);
    step("rdN5", 0, 0, 0, 0, 1, 32'h108, 1, 32'h110);

    // Fill while stalled, then redirect+stall together
    step("full0", 0, 0, 0, 1, 1, 32'h10C, 0, 0);
    step("full1", 0, 0, 0, 1, 1, 32'h10C, 0, 0);
    step("rdst",  0, 1, 32'h200, 1, 0, 0, 0, 0);
    step("rdst1", 0, 0, 0, 0, 0, 0, 1, 32'h200);
    step("rdst2", 0, 0, 0, 0, 0, 0, 1, 32'h204);
    step("rdst3", 0, 0, 0, 0, 1, 32'h200, 1, 32'h208);
    step("rdst4", 0, 0, 0, 0, 1, 32'h204, 1, 32'h20C);

    // Back-to-back redirects, last one wins, then address wrap
    step("bb0",  0, 1, 32'h300, 0, 0, 0, 0, 0);
    step("bb1",  0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    step("wrp0", 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step("wrp1", 0, 0, 0, 0, 0, 0, 1, 32'h0);
    step("wrp2", 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h4);
    step("wrp3", 0, 0, 0, 0, 1, 32'h0, 1, 32'h8);
    step("wrp4", 0, 0, 0, 0, 1, 32'h4, 1, 32'hC);

    // Reset mid-operation behaves like power-on
    step("mrst", 1, 0, 0, 0, 0, 0, 0, 0);
    check("mrst.addr", imemAddr, 32'h0);
    bub_exp = 0;
    redir_exp = 0;
    step("d0",  0, 0, 0, 0, 0, 0, 1, 32'h0);
    step("d1",  0, 0, 0, 0, 0, 0, 1, 32'h4);
    step("d2",  0, 0, 0, 0, 1, 32'h0, 1, 32'h8);
    step("d3",  0, 0, 0, 0, 1, 32'h4, 1, 32'hC);
    step("d4",  0, 1, 32'h40, 0, 0, 0, 0, 0);
    step("d5",  0, 0, 0, 0, 0, 0, 1, 32'h40);
    step("d6",  0, 0, 0, 0, 0, 0, 1, 32'h44);
    step("d7",  0, 0, 0, 0, 1, 32'h40, 1, 32'h48);
    step("d8",  0, 0, 0, 0, 1, 32'h44, 1, 32'h4C);
    step("d9",  0, 1, 32'h80, 0, 0, 0, 0, 0);
    step("d10", 0, 1, 32'h90, 0, 0, 0, 0, 0);
    step("d11", 0, 0, 0, 0, 0, 0, 1, 32'h90);
    step("d12", 0, 0, 0, 0, 0, 0, 1, 32'h94);
    step("d13", 0, 0, 0, 0, 1, 32'h90, 1, 32'h98);
    for (int k = 0; k < 4; k++)
      step("dst", 0, 0, 0, 1, 1, 32'h94, 0, 0);
    step("d18", 0, 0, 0, 0, 1, 32'h94, 1, 32'h9C);
    step("d19", 0, 0, 0, 0, 1, 32'h98, 1, 32'hA0);
`ifdef FETCH_PERF_EN
    check("redirectCnt", redirectCnt, 32'd3);
    check("redirectExp", redirectCnt, 32'(redir_exp));
    check("bubbleCnt",   bubbleCnt,   32'd9);
    check("bubbleExp",   bubbleCnt,   32'(bub_exp));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
